// File: rtl/lamp_cycle_ctrl_pkg.sv
// Shared types and widths for the lamp sequencer: state encoding, counter widths,
// and the key-event payload passed from the key front end to the sequencer.
package lamp_cycle_ctrl_pkg;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned LIGHT_W = 3;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic long_evt;
    logic short_evt;
  } key_evt_t;

endpackage

// File: rtl/lamp_cycle_ctrl_key_press.sv
// Key front end: 2-flop synchroniser, debounce filter, hold timer and
// one-cycle short/long press events.
module key_press
  import lamp_cycle_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 500000,
  parameter int unsigned LONG_TICKS     = 100000000
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     key,
  output key_evt_t evt
);

  logic             sync_a;
  logic             sync_b;
  logic             deb;
  logic             deb_d;
  logic             deb_nxt;
  logic             rise;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;

  // Hold time counts the cycle in which the debounced level rises, so a press
  // held LONG_TICKS cycles fires its long event on that same edge.
  always_comb begin
    deb_nxt = deb;
    if ((sync_b != deb) && (deb_cnt == CNT_W'(DEBOUNCE_TICKS - 1)))
      deb_nxt = sync_b;
    rise     = deb_nxt & ~deb;
    hold_nxt = hold_cnt;
    if (rise)
      hold_nxt = CNT_W'(1);
    else if (deb && deb_nxt && (hold_cnt != CNT_W'(LONG_TICKS)))
      hold_nxt = hold_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a   <= 1'b0;
      sync_b   <= 1'b0;
      deb      <= 1'b0;
      deb_d    <= 1'b0;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      evt      <= '0;
    end else begin
      sync_a        <= key;
      sync_b        <= sync_a;
      deb           <= deb_nxt;
      deb_d         <= deb;
      deb_cnt       <= ((sync_b == deb) || (deb_nxt != deb)) ? '0 : deb_cnt + CNT_W'(1);
      hold_cnt      <= hold_nxt;
      evt.long_evt  <= deb_nxt && (hold_nxt == CNT_W'(LONG_TICKS)) &&
                       (rise || (hold_cnt != CNT_W'(LONG_TICKS)));
      // Hold count freezes after release, so it still tells short from long here.
      evt.short_evt <= deb_d && !deb && (hold_cnt < CNT_W'(LONG_TICKS));
    end
  end

endmodule

// File: rtl/lamp_cycle_ctrl.sv
// Multi-colour lamp sequencer: one key steps through colours with unlit gaps,
// gaps time out to off, a long press forces off; BCD count of gap time.
module lamp_cycle_ctrl
  import lamp_cycle_ctrl_pkg::*;
#(
  parameter int unsigned NUM_COLORS     = 3,
  parameter int unsigned UNIT_TICKS     = 5000000,
  parameter int unsigned NORMAL_TICKS   = 50000000,
  parameter int unsigned SLOW_TICKS     = 500000000,
  parameter int unsigned DEBOUNCE_TICKS = 500000,
  parameter int unsigned LONG_TICKS     = 100000000,
  parameter int unsigned BCD_DIGITS     = 2
) (
  input  logic                    Sys_CLK,
  input  logic                    Sys_RST,
  input  logic                    Key_In,
  input  logic                    Mode,
  output logic [LIGHT_W-1:0]      Light,
  output logic [STATE_W-1:0]      State,
  output logic [COLOR_W-1:0]      Color,
  output logic [4*BCD_DIGITS-1:0] Number,
  output logic                    Timeout
);

  key_evt_t                evt;
  state_e                  state_q, state_nxt;
  logic [COLOR_W-1:0]      color_q, color_nxt;
  logic [LIGHT_W-1:0]      light_q, light_nxt;
  logic                    timeout_q, timeout_nxt;
  logic [CNT_W-1:0]        gap_cnt, gap_cnt_nxt;
  logic [CNT_W-1:0]        gap_lim, gap_lim_nxt;
  logic [CNT_W-1:0]        unit_cnt, unit_cnt_nxt;
  logic                    expired;
  logic                    bcd_clr;
  logic                    bcd_inc;
  logic [4*BCD_DIGITS-1:0] number_q, number_nxt;
  logic [BCD_DIGITS-1:0]   carry;

  key_press #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .LONG_TICKS    (LONG_TICKS)
  ) u_key_press (
    .clk  (Sys_CLK),
    .rst_n(Sys_RST),
    .key  (Key_In),
    .evt  (evt)
  );

  // Sequencer; a short press beats a simultaneous gap expiry.
  always_comb begin
    state_nxt   = state_q;
    color_nxt   = color_q;
    timeout_nxt = 1'b0;
    gap_lim_nxt = gap_lim;
    gap_cnt_nxt = (state_q == ST_GAP) ? gap_cnt + CNT_W'(1) : gap_cnt;
    expired     = (gap_cnt == gap_lim - CNT_W'(1));
    case (state_q)
      ST_IDLE: begin
        color_nxt = '0;
        if (evt.short_evt) state_nxt = ST_ON;
      end
      ST_ON: begin
        if (evt.long_evt) begin
          state_nxt = ST_IDLE;
          color_nxt = '0;
        end else if (evt.short_evt) begin
          if (color_q == COLOR_W'(NUM_COLORS - 1)) begin
            state_nxt = ST_IDLE;
            color_nxt = '0;
          end else begin
            state_nxt   = ST_GAP;
            color_nxt   = color_q + COLOR_W'(1);
            gap_cnt_nxt = '0;
            gap_lim_nxt = Mode ? CNT_W'(SLOW_TICKS) : CNT_W'(NORMAL_TICKS);
          end
        end
      end
      ST_GAP: begin
        if (evt.long_evt) begin
          state_nxt = ST_IDLE;
          color_nxt = '0;
        end else if (evt.short_evt) begin
          state_nxt = ST_ON;
        end else if (expired) begin
          state_nxt   = ST_IDLE;
          color_nxt   = '0;
          timeout_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        color_nxt = '0;
      end
    endcase
    light_nxt = (state_nxt == ST_ON) ? LIGHT_W'(color_nxt) + LIGHT_W'(1) : '0;
  end

  // Unit prescaler runs only while the gap persists across the edge.
  always_comb begin
    unit_cnt_nxt = '0;
    bcd_clr      = 1'b1;
    bcd_inc      = 1'b0;
    if (state_nxt == ST_GAP) begin
      bcd_clr = 1'b0;
      if (state_q == ST_GAP) begin
        if (unit_cnt == CNT_W'(UNIT_TICKS - 1))
          bcd_inc = 1'b1;
        else
          unit_cnt_nxt = unit_cnt + CNT_W'(1);
      end
    end
  end

  assign carry[0] = bcd_inc;

  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
    logic [3:0] digit;
    assign digit = number_q[4*gi +: 4];
    assign number_nxt[4*gi +: 4] = bcd_clr          ? 4'd0 :
                                   !carry[gi]       ? digit :
                                   (digit == 4'd9)  ? 4'd0 : digit + 4'd1;
    if (gi < int'(BCD_DIGITS) - 1) begin : g_carry
      assign carry[gi+1] = carry[gi] && (digit == 4'd9);
    end
  end

  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      state_q   <= ST_IDLE;
      color_q   <= '0;
      light_q   <= '0;
      timeout_q <= 1'b0;
      gap_cnt   <= '0;
      gap_lim   <= '0;
      unit_cnt  <= '0;
      number_q  <= '0;
    end else begin
      state_q   <= state_nxt;
      color_q   <= color_nxt;
      light_q   <= light_nxt;
      timeout_q <= timeout_nxt;
      gap_cnt   <= gap_cnt_nxt;
      gap_lim   <= gap_lim_nxt;
      unit_cnt  <= unit_cnt_nxt;
      number_q  <= number_nxt;
    end
  end

  assign Light   = light_q;
  assign State   = state_q;
  assign Color   = color_q;
  assign Number  = number_q;
  assign Timeout = timeout_q;

endmodule

// File: tb/tb_lamp_cycle_ctrl.sv
// Bench for lamp_cycle_ctrl: time-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized key traffic.
module tb_lamp_cycle_ctrl;

  localparam int NC = 3;
  localparam int UT = 10;
  localparam int NT = 100;
  localparam int ST = 300;
  localparam int DT = 4;
  localparam int LT = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key;
  logic       mode;
  logic [2:0] light, color, light1, color1;
  logic [1:0] state, state1;
  logic [7:0] num;
  logic [3:0] num1;
  logic       to, to1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lamp_cycle_ctrl #(
    .NUM_COLORS(NC), .UNIT_TICKS(UT), .NORMAL_TICKS(NT), .SLOW_TICKS(ST),
    .DEBOUNCE_TICKS(DT), .LONG_TICKS(LT), .BCD_DIGITS(2)
  ) dut (
    .Sys_CLK(clk), .Sys_RST(rst_n), .Key_In(key), .Mode(mode),
    .Light(light), .State(state), .Color(color), .Number(num), .Timeout(to)
  );

  lamp_cycle_ctrl #(
    .NUM_COLORS(NC), .UNIT_TICKS(UT), .NORMAL_TICKS(NT), .SLOW_TICKS(ST),
    .DEBOUNCE_TICKS(DT), .LONG_TICKS(LT), .BCD_DIGITS(1)
  ) dut1 (
    .Sys_CLK(clk), .Sys_RST(rst_n), .Key_In(key), .Mode(mode),
    .Light(light1), .State(state1), .Color(color1), .Number(num1), .Timeout(to1)
  );

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: edge index n since reset, key samples in a queue,
  // events and timeouts derived from edge arithmetic.
  bit kh[$];
  int n, m_rise, m_short_at, m_state, m_color, m_entry, m_limit, u;
  bit m_deb, lng, sht, flip;
  int e_light, e_state, e_color, e_num2, e_num1, e_to;

  always @(posedge clk) begin
    if (!rst_n) begin
      kh.delete();
      for (int i = 0; i < DT + 2; i++) kh.push_back(1'b0);
      n = 0; m_deb = 0; m_rise = -1000000; m_short_at = -1;
      m_state = 0; m_color = 0; m_entry = 0; m_limit = 0;
      e_light = 0; e_state = 0; e_color = 0; e_num2 = 0; e_num1 = 0; e_to = 0;
    end else begin
      n++;
      kh.push_front(key);
      void'(kh.pop_back());
      lng = m_deb && (n == m_rise + LT);
      sht = (n == m_short_at);
      flip = 1;
      for (int i = 2; i < DT + 2; i++) if (kh[i] == m_deb) flip = 0;
      if (flip) begin
        m_deb = !m_deb;
        if (m_deb) m_rise = n;
        else if (n - m_rise < LT) m_short_at = n + 2;
      end
      e_to = 0;
      case (m_state)
        0: if (sht) m_state = 1;
        1: begin
          if (lng) m_state = 0;
          else if (sht) begin
            if (m_color == NC - 1) m_state = 0;
            else begin
              m_state = 2; m_color++; m_entry = n; m_limit = mode ? ST : NT;
            end
          end
        end
        default: begin
          if (lng) m_state = 0;
          else if (sht) m_state = 1;
          else if (n == m_entry + m_limit) begin m_state = 0; e_to = 1; end
        end
      endcase
      if (m_state == 0) m_color = 0;
      e_state = m_state;
      e_color = m_color;
      e_light = (m_state == 1) ? m_color + 1 : 0;
      u = (m_state == 2) ? (n - m_entry) / UT : 0;
      e_num2 = ((u / 10) % 10) * 16 + (u % 10);
      e_num1 = u % 10;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("light", light, e_light);
      chk("state", state, e_state);
      chk("color", color, e_color);
      chk("number", num, e_num2);
      chk("timeout", to, e_to);
      chk("number1", num1, e_num1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int len);
    key = 1'b1;
    repeat (len) tick();
    key = 1'b0;
  endtask

  task automatic wait_state(input string name, input int target, input int budget);
    int i;
    i = 0;
    while (state != 2'(target) && i < budget) begin
      tick();
      i++;
    end
    chk(name, state, target);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_light[6];
    int exp_color[6];
    exp_light = '{1, 0, 2, 0, 3, 0};
    exp_color = '{0, 1, 1, 2, 2, 0};
    rst_n = 1'b0; key = 1'b0; mode = 1'b0;
    repeat (3) tick();
    chk("rst_light", light, 0); chk("rst_state", state, 0); chk("rst_color", color, 0);
    chk("rst_number", num, 0); chk("rst_timeout", to, 0);
    rst_n = 1'b1;

    // Bounce never survives the filter.
    for (int i = 0; i < 20; i++) begin
      key = ((i / 2) % 2 == 0);
      tick();
    end
    key = 1'b0;
    repeat (20) tick();
    chk("bounce_state", state, 0);

    // Full colour cycle.
    for (int k = 0; k < 6; k++) begin
      press(10);
      repeat (20) tick();
      chk("cycle_light", light, exp_light[k]);
      chk("cycle_color", color, exp_color[k]);
    end
    chk("cycle_end_state", state, 0);

    // Normal gap timeout.
    press(10); wait_state("to_on", 1, 20);
    mode = 1'b0;
    press(10); wait_state("to_gap", 2, 20);
    repeat (99) tick();
    chk("to_last_state", state, 2); chk("to_last_num", num, 8'h09);
    chk("to_last_num1", num1, 9); chk("to_last_pulse", to, 0);
    tick();
    chk("to_exp_state", state, 0); chk("to_exp_pulse", to, 1); chk("to_exp_num", num, 0);
    tick();
    chk("to_pulse_end", to, 0);

    // Short press landing on the expiry edge wins.
    press(10); wait_state("sim_on", 1, 20);
    press(10); wait_state("sim_gap", 2, 20);
    repeat (82) tick();
    press(10);
    repeat (7) tick();
    chk("sim_pre_state", state, 2);
    tick();
    chk("sim_state", state, 1); chk("sim_pulse", to, 0);

    // Long press from ON with Color=1.
    chk("long_color", color, 1);
    key = 1'b1;
    repeat (55) tick();
    chk("long_pre_state", state, 1);
    tick();
    chk("long_state", state, 0); chk("long_light", light, 0);
    repeat (4) tick();
    key = 1'b0;
    repeat (30) tick();
    chk("long_release_state", state, 0);

    // Slow mode with Mode flipped mid-gap; one-digit counter wraps.
    press(10); wait_state("slow_on", 1, 20);
    mode = 1'b1;
    press(10); wait_state("slow_gap", 2, 20);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 50) mode = 1'b0;
      if (i == 99) chk("wrap_nine", num1, 9);
      if (i == 100) begin chk("wrap_zero", num1, 0); chk("wrap_num2", num, 8'h10); end
      if (i == 110) chk("wrap_one", num1, 1);
      if (i == 299) begin chk("slow_last_state", state, 2); chk("slow_last_num", num, 8'h29); end
      if (i == 300) begin chk("slow_exp_state", state, 0); chk("slow_exp_pulse", to, 1); end
    end

    // Asynchronous reset in the middle of a gap.
    press(10); wait_state("rst_on", 1, 20);
    press(10); wait_state("rst_gap", 2, 20);
    repeat (15) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_light", light, 0); chk("mid_rst_state", state, 0);
    chk("mid_rst_color", color, 0); chk("mid_rst_number", num, 0);
    chk("mid_rst_timeout", to, 0); chk("mid_rst_number1", num1, 0);
    chk("mid_rst_state1", state1, 0); chk("mid_rst_light1", light1, 0);
    chk("mid_rst_color1", color1, 0); chk("mid_rst_timeout1", to1, 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_state", state, 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 50; it++) begin
      mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < int'($urandom_range(2, 8)); j++) begin
          key = ~key;
          repeat ($urandom_range(1, 3)) tick();
        end
        key = 1'b0;
      end
      press(int'($urandom_range(1, 70)));
      repeat ($urandom_range(1, 160)) tick();
    end
    key = 1'b0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
